// File: rtl/switch_stats_monitor_pkg.sv
// Shared types and helpers for the switch statistics monitor.
// Holds the read-select encoding, check FSM states and popcount.
package switch_stats_monitor_pkg;

  localparam int PC_W = 5;

  typedef enum logic [1:0] {
    SEL_ACC = 2'd0,
    SEL_DRP = 2'd1,
    SEL_DEL = 2'd2,
    SEL_FLG = 2'd3
  } rd_sel_e;

  typedef enum logic [1:0] {
    CHK_IDLE    = 2'd0,
    CHK_QUIET   = 2'd1,
    CHK_COMPARE = 2'd2,
    CHK_DONE    = 2'd3
  } chk_state_e;

  function automatic logic [PC_W-1:0] popcount(
    input logic [15:0] v
  );
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + PC_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/switch_stats_monitor_port_stat_counter.sv
// One port's saturating accepted/dropped/delivered counters,
// their shadow copies and the sticky saturation flag.
module port_stat_counter
  import switch_stats_monitor_pkg::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid_in_i,
  input  logic                 fifo_full_i,
  input  logic                 valid_out_i,
  input  logic                 clear_i,
  input  logic                 snap_i,
  input  logic [PC_W-1:0]      weight_i,
  output logic [CNT_WIDTH-1:0] acc_o,
  output logic [CNT_WIDTH-1:0] del_o,
  output logic [CNT_WIDTH-1:0] sh_acc_o,
  output logic [CNT_WIDTH-1:0] sh_drp_o,
  output logic [CNT_WIDTH-1:0] sh_del_o,
  output logic                 sat_o,
  output logic                 sh_sat_o
);

  localparam int SW = CNT_WIDTH + PC_W + 1;
  localparam logic [CNT_WIDTH-1:0] MAXV = '1;

  // Returns {overflowed, clamped sum}.
  function automatic logic [CNT_WIDTH:0] sat_add(
    input logic [CNT_WIDTH-1:0] a,
    input logic [PC_W-1:0]      b
  );
    logic [SW-1:0] s;
    s = SW'(a) + SW'(b);
    if (s > SW'(MAXV)) begin
      return {1'b1, MAXV};
    end
    return {1'b0, s[CNT_WIDTH-1:0]};
  endfunction

  logic [CNT_WIDTH-1:0] acc_q, acc_d, acc_n;
  logic [CNT_WIDTH-1:0] drp_q, drp_d, drp_n;
  logic [CNT_WIDTH-1:0] del_q, del_d, del_n;
  logic [CNT_WIDTH-1:0] sh_acc_q, sh_acc_d;
  logic [CNT_WIDTH-1:0] sh_drp_q, sh_drp_d;
  logic [CNT_WIDTH-1:0] sh_del_q, sh_del_d;
  logic                 sat_q, sat_d, sat_n;
  logic                 sh_sat_q, sh_sat_d;
  logic                 acc_ovf, drp_ovf, del_ovf;
  logic [PC_W-1:0]      acc_w, drp_w, del_w;

  always_comb begin
    acc_w = (valid_in_i && !fifo_full_i) ? weight_i : '0;
    drp_w = (valid_in_i && fifo_full_i) ? weight_i : '0;
    del_w = PC_W'(valid_out_i);
    {acc_ovf, acc_n} = sat_add(acc_q, acc_w);
    {drp_ovf, drp_n} = sat_add(drp_q, drp_w);
    {del_ovf, del_n} = sat_add(del_q, del_w);
    sat_n = sat_q | acc_ovf | drp_ovf | del_ovf;
    // Shadow captures this cycle's events even when clear wipes live.
    sh_acc_d = snap_i ? acc_n : sh_acc_q;
    sh_drp_d = snap_i ? drp_n : sh_drp_q;
    sh_del_d = snap_i ? del_n : sh_del_q;
    sh_sat_d = snap_i ? sat_n : sh_sat_q;
    acc_d = clear_i ? '0 : acc_n;
    drp_d = clear_i ? '0 : drp_n;
    del_d = clear_i ? '0 : del_n;
    sat_d = clear_i ? 1'b0 : sat_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      drp_q    <= '0;
      del_q    <= '0;
      sat_q    <= 1'b0;
      sh_acc_q <= '0;
      sh_drp_q <= '0;
      sh_del_q <= '0;
      sh_sat_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      drp_q    <= drp_d;
      del_q    <= del_d;
      sat_q    <= sat_d;
      sh_acc_q <= sh_acc_d;
      sh_drp_q <= sh_drp_d;
      sh_del_q <= sh_del_d;
      sh_sat_q <= sh_sat_d;
    end
  end

  assign acc_o    = acc_q;
  assign del_o    = del_q;
  assign sh_acc_o = sh_acc_q;
  assign sh_drp_o = sh_drp_q;
  assign sh_del_o = sh_del_q;
  assign sat_o    = sat_q;
  assign sh_sat_o = sh_sat_q;

endmodule

// File: rtl/switch_stats_monitor.sv
// N-port traffic statistics engine: per-port counters, shadow
// read bank and a quiet-window drain check reporting loss.
module switch_stats_monitor
  import switch_stats_monitor_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int CNT_WIDTH    = 16,
  parameter int QUIET_CYCLES = 32,
  parameter int MAX_WAIT     = 4096
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [NUM_PORTS-1:0]                valid_in,
  input  logic [NUM_PORTS*NUM_PORTS-1:0]      target_in,
  input  logic [NUM_PORTS-1:0]                fifo_full,
  input  logic [NUM_PORTS-1:0]                valid_out,
  input  logic                                clear,
  input  logic                                snap,
  input  logic [$clog2(NUM_PORTS)-1:0]        rd_port,
  input  logic [1:0]                          rd_sel,
  output logic [CNT_WIDTH-1:0]                rd_data,
  output logic [NUM_PORTS-1:0]                sat_flag,
  input  logic                                check_req,
  output logic                                check_busy,
  output logic                                check_done,
  output logic                                check_pass,
  output logic                                check_timeout,
  output logic [CNT_WIDTH+$clog2(NUM_PORTS):0] loss_count
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int TW = CNT_WIDTH + PW;
  localparam int LW = TW + 1;
  localparam int IW = $clog2(QUIET_CYCLES + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [CNT_WIDTH-1:0] acc_live [NUM_PORTS];
  logic [CNT_WIDTH-1:0] del_live [NUM_PORTS];
  logic [CNT_WIDTH-1:0] sh_acc   [NUM_PORTS];
  logic [CNT_WIDTH-1:0] sh_drp   [NUM_PORTS];
  logic [CNT_WIDTH-1:0] sh_del   [NUM_PORTS];
  logic [NUM_PORTS-1:0] sh_sat;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [PC_W-1:0] weight;
    assign weight = popcount(16'(target_in[p*NUM_PORTS +: NUM_PORTS]));

    port_stat_counter #(
      .CNT_WIDTH(CNT_WIDTH)
    ) u_cnt (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in_i (valid_in[p]),
      .fifo_full_i(fifo_full[p]),
      .valid_out_i(valid_out[p]),
      .clear_i    (clear),
      .snap_i     (snap),
      .weight_i   (weight),
      .acc_o      (acc_live[p]),
      .del_o      (del_live[p]),
      .sh_acc_o   (sh_acc[p]),
      .sh_drp_o   (sh_drp[p]),
      .sh_del_o   (sh_del[p]),
      .sat_o      (sat_flag[p]),
      .sh_sat_o   (sh_sat[p])
    );
  end

  logic [TW-1:0]        acc_tot, del_tot;
  logic [LW-1:0]        loss_now;
  logic                 act;

  always_comb begin
    acc_tot = '0;
    del_tot = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      acc_tot = acc_tot + TW'(acc_live[p]);
      del_tot = del_tot + TW'(del_live[p]);
    end
    loss_now = LW'(acc_tot) - LW'(del_tot);
    act = (|valid_in) || (|valid_out);
  end

  chk_state_e           st_q, st_d;
  logic [IW-1:0]        idle_q, idle_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [LW-1:0]        loss_q, loss_d;
  logic                 pass_q, pass_d;
  logic                 to_q, to_d;
  logic [CNT_WIDTH-1:0] rd_q, rd_d;

  always_comb begin
    st_d   = st_q;
    idle_d = idle_q;
    wait_d = wait_q;
    loss_d = loss_q;
    pass_d = pass_q;
    to_d   = to_q;
    unique case (st_q)
      CHK_IDLE: begin
        if (check_req) begin
          st_d   = CHK_QUIET;
          idle_d = '0;
          wait_d = '0;
        end
      end
      CHK_QUIET: begin
        idle_d = act ? '0 : idle_q + 1'b1;
        wait_d = wait_q + 1'b1;
        if (idle_q == IW'(QUIET_CYCLES)) begin
          st_d = CHK_COMPARE;
        end else if (wait_q == WW'(MAX_WAIT)) begin
          st_d   = CHK_DONE;
          loss_d = loss_now;
          to_d   = 1'b1;
          pass_d = 1'b0;
        end
      end
      CHK_COMPARE: begin
        st_d   = CHK_DONE;
        loss_d = loss_now;
        to_d   = 1'b0;
        pass_d = (loss_now == '0) && !(|sat_flag);
      end
      CHK_DONE: begin
        st_d = CHK_IDLE;
      end
    endcase
    // Clear aborts a running check and drops held results.
    if (clear) begin
      st_d   = CHK_IDLE;
      loss_d = '0;
      pass_d = 1'b0;
      to_d   = 1'b0;
    end
  end

  always_comb begin
    rd_d = '0;
    unique case (rd_sel_e'(rd_sel))
      SEL_ACC: rd_d = sh_acc[rd_port];
      SEL_DRP: rd_d = sh_drp[rd_port];
      SEL_DEL: rd_d = sh_del[rd_port];
      SEL_FLG: rd_d = CNT_WIDTH'({sh_sat[rd_port], to_q});
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= CHK_IDLE;
      idle_q <= '0;
      wait_q <= '0;
      loss_q <= '0;
      pass_q <= 1'b0;
      to_q   <= 1'b0;
      rd_q   <= '0;
    end else begin
      st_q   <= st_d;
      idle_q <= idle_d;
      wait_q <= wait_d;
      loss_q <= loss_d;
      pass_q <= pass_d;
      to_q   <= to_d;
      rd_q   <= rd_d;
    end
  end

  assign rd_data       = rd_q;
  assign check_busy    = (st_q != CHK_IDLE);
  assign check_done    = (st_q == CHK_DONE);
  assign check_pass    = pass_q;
  assign check_timeout = to_q;
  assign loss_count    = loss_q;

endmodule
